// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: sample width, Q2.10 unity,
// sweep state type and the bit-reverse helper.
package fft_pkg;

  localparam int DATA_W    = 12;
  localparam int Q_ONE     = 1024;
  localparam int MAX_LOG2N = 6;

  typedef enum logic {SW_IDLE, SW_READ} sweep_e;

  // Reverse all MAX_LOG2N bits, then shift so only the low nbits are reversed.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] k,
                                                  input int unsigned nbits);
    logic [MAX_LOG2N-1:0] r;
    for (int i = 0; i < MAX_LOG2N; i++) r[i] = k[MAX_LOG2N-1-i];
    return r >> (MAX_LOG2N - nbits);
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N-entry reorder bank: single write port, registered read port.
// Memory contents are deliberately not reset.
module reorder_bank #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int W     = 24
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder of bit-reversed FFT output into natural order.
// Optional FFT_REORDER_FRAME_MARK_EN adds out_sof/out_eof frame markers.
module fft_reorder #(
  parameter int N      = 8,
  parameter int LOG2N  = 3,
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x_r,
  input  logic [DATA_W-1:0] x_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] X_r,
  output logic [DATA_W-1:0] X_i,
  output logic [LOG2N-1:0]  bin_idx
`ifdef FFT_REORDER_FRAME_MARK_EN
  ,
  output logic              out_sof,
  output logic              out_eof
`endif
);
  import fft_pkg::*;

  localparam int W = 2 * DATA_W;

  sweep_e             st_q, st_d;
  logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [LOG2N-1:0]   rd_idx_q, rd_idx_d, bin_q, bin_d, wr_addr;
  logic               bank_sel_q, bank_sel_d, rd_sel_q, rd_sel_d, swap;
  logic [1:0]         vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0]  xr_q, xr_d, xi_q, xi_d;
  logic [1:0][W-1:0]  rd_data;
  logic [W-1:0]       rd_word;
`ifdef FFT_REORDER_FRAME_MARK_EN
  logic               sof_q, sof_d, eof_q, eof_d;
`endif

  // bank_sel_q is the write bank; the sweep always reads the other one.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(.N(N), .LOG2N(LOG2N), .W(W)) u_bank (
      .clk   (clk),
      .we    (in_valid && (bank_sel_q == 1'(b))),
      .waddr (wr_addr),
      .wdata ({x_r, x_i}),
      .raddr (rd_cnt_q),
      .rdata (rd_data[b])
    );
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    bank_sel_d = bank_sel_q;
    st_d       = st_q;
    wr_addr    = LOG2N'(bitrev(MAX_LOG2N'(wr_cnt_q), LOG2N));
    swap       = in_valid && (wr_cnt_q == LOG2N'(N - 1));

    if (in_valid) wr_cnt_d = wr_cnt_q + 1'b1;
    if (st_q == SW_READ) begin
      if (rd_cnt_q == LOG2N'(N - 1)) st_d = SW_IDLE;
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    // A swap may land on the last read of the previous sweep: restart cleanly.
    if (swap) begin
      bank_sel_d = ~bank_sel_q;
      st_d       = SW_READ;
      rd_cnt_d   = '0;
    end

    vld_pipe_d = {vld_pipe_q[0], st_q == SW_READ};
    rd_idx_d   = rd_cnt_q;
    rd_sel_d   = ~bank_sel_q;
    rd_word    = rd_data[rd_sel_q];
    xr_d       = vld_pipe_q[0] ? rd_word[W-1:DATA_W] : '0;
    xi_d       = vld_pipe_q[0] ? rd_word[DATA_W-1:0] : '0;
    bin_d      = vld_pipe_q[0] ? rd_idx_q : '0;
`ifdef FFT_REORDER_FRAME_MARK_EN
    sof_d      = vld_pipe_q[0] && (rd_idx_q == '0);
    eof_d      = vld_pipe_q[0] && (rd_idx_q == LOG2N'(N - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= SW_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      bank_sel_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_idx_q   <= '0;
      vld_pipe_q <= '0;
      xr_q       <= '0;
      xi_q       <= '0;
      bin_q      <= '0;
`ifdef FFT_REORDER_FRAME_MARK_EN
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
`endif
    end else begin
      st_q       <= st_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      bank_sel_q <= bank_sel_d;
      rd_sel_q   <= rd_sel_d;
      rd_idx_q   <= rd_idx_d;
      vld_pipe_q <= vld_pipe_d;
      xr_q       <= xr_d;
      xi_q       <= xi_d;
      bin_q      <= bin_d;
`ifdef FFT_REORDER_FRAME_MARK_EN
      sof_q      <= sof_d;
      eof_q      <= eof_d;
`endif
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign X_r       = xr_q;
  assign X_i       = xi_q;
  assign bin_idx   = bin_q;
`ifdef FFT_REORDER_FRAME_MARK_EN
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Randomized bench for fft_reorder against a frame-level reference model that
// schedules natural-order bins two cycles after each completed frame.
module tb_fft_reorder;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int DW    = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     x_r = '0, x_i = '0;
  logic              out_valid;
  logic [DW-1:0]     X_r, X_i;
  logic [LOG2N-1:0]  bin_idx;
`ifdef FFT_REORDER_FRAME_MARK_EN
  logic              out_sof, out_eof;
`endif

  int errors = 0, checks = 0, cyc = 0, kcnt = 0;
  int fr_r[N], fr_i[N];
  int exp_r[int], exp_i[int], exp_b[int];

  fft_reorder #(.N(N), .LOG2N(LOG2N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_r       (x_r),
    .x_i       (x_i),
    .out_valid (out_valid),
    .X_r       (X_r),
    .X_i       (X_i),
    .bin_idx   (bin_idx)
`ifdef FFT_REORDER_FRAME_MARK_EN
    ,
    .out_sof   (out_sof),
    .out_eof   (out_eof)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r |= ((k >> i) & 1) << (LOG2N - 1 - i);
    return r;
  endfunction

  // Reference: natural bin n of a frame is the sample accepted at position brev(n).
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      kcnt = 0;
      exp_r.delete(); exp_i.delete(); exp_b.delete();
    end else if (in_valid) begin
      fr_r[kcnt] = int'($signed(x_r));
      fr_i[kcnt] = int'($signed(x_i));
      if (kcnt == N - 1)
        for (int n = 0; n < N; n++) begin
          exp_r[cyc + 2 + n] = fr_r[brev(n)];
          exp_i[cyc + 2 + n] = fr_i[brev(n)];
          exp_b[cyc + 2 + n] = n;
        end
      kcnt = (kcnt + 1) % N;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (exp_r.exists(cyc)) begin
        chk("out_valid", out_valid, 1);
        chk("X_r", $signed(X_r), exp_r[cyc]);
        chk("X_i", $signed(X_i), exp_i[cyc]);
        chk("bin_idx", bin_idx, exp_b[cyc]);
`ifdef FFT_REORDER_FRAME_MARK_EN
        chk("out_sof", out_sof, (exp_b[cyc] == 0) ? 1 : 0);
        chk("out_eof", out_eof, (exp_b[cyc] == N - 1) ? 1 : 0);
`endif
      end else begin
        chk("out_valid_idle", out_valid, 0);
        chk("X_r_idle", $signed(X_r), 0);
        chk("X_i_idle", $signed(X_i), 0);
        chk("bin_idx_idle", bin_idx, 0);
`ifdef FFT_REORDER_FRAME_MARK_EN
        chk("out_sof_idle", out_sof, 0);
        chk("out_eof_idle", out_eof, 0);
`endif
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] r, input logic [DW-1:0] i);
    @(posedge clk); #2;
    in_valid = v; x_r = r; x_i = i;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, DW'($urandom), DW'($urandom));
  endtask

  task automatic pulse_rst();
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic directed_frame();
    for (int k = 0; k < N; k++) drive(1'b1, DW'(16 * brev(k)), DW'(-16 * brev(k)));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Known-value frame: natural output 0,16,..,112 / 0,-16,..,-112.
    directed_frame();
    idle(N + 4);

    // Three back-to-back random frames.
    for (int k = 0; k < 3 * N; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    idle(N + 4);

    // Alternating valid/gap through one frame.
    for (int k = 0; k < N; k++) begin
      drive(1'b1, DW'(16 * brev(k)), DW'(-16 * brev(k)));
      drive(1'b0, DW'($urandom), DW'($urandom));
    end
    idle(N + 4);

    // Partial frame discarded by reset, then a clean frame.
    for (int k = 0; k < 5; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    pulse_rst();
    directed_frame();
    idle(N + 4);

    // Reset while bin 3 is on the output.
    directed_frame();
    idle(5);
    pulse_rst();
    idle(N + 4);

    // Random gaps across several frames, including full-scale extremes.
    for (int acc = 0; acc < 4 * N; ) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, DW'($urandom), DW'($urandom));
      else begin
        if (acc == 3) drive(1'b1, DW'(12'h7FF), DW'(12'h800));
        else drive(1'b1, DW'($urandom), DW'($urandom));
        acc++;
      end
    end
    idle(N + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
